lcd_spi_rx_decoder: RTL

- Receive-side counterpart of the LCD SPI write path. Samples the 4-wire LCD bus (cs, dc, sclk, mosi) in the clk_25MHz domain and reassembles bytes.
- Decodes the ST7789-style command subset used by the display blocks: CASET 0x2A, RASET 0x2B, RAMWR 0x2C.
- Emits per-pixel writes with screen coordinates and a frame-complete pulse.
- Used as a loopback monitor and scoreboard source for display verification, and as a framebuffer-mirror feeder.

---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_spi_byte_rx.sv | 70 +++++++
 rtl/lcd_spi_rx_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and decoder state type for the LCD SPI receive path.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int unsigned LCD_H_RES = 160;
  localparam int unsigned LCD_V_RES = 240;

  typedef enum logic [1:0] {
    StIdle,
    StCaset,
    StRaset,
    StRamwr
  } dec_state_e;

endpackage

// File: rtl/lcd_spi_byte_rx.sv
// Samples the asynchronous 4-wire LCD bus and reassembles MSB-first bytes.
// byte_ready is a one-cycle early strobe so the decoder can register pixel outputs alongside byte_valid.
module lcd_spi_byte_rx (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       byte_ready,
  output logic [7:0] ready_data,
  output logic       ready_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] cs_s;
  logic [1:0] dc_s;
  logic [1:0] mosi_s;
  logic [2:0] sclk_s;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic       sclk_rise;

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      cs_s       <= 2'b11;
      dc_s       <= '0;
      mosi_s     <= '0;
      sclk_s     <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      byte_ready <= 1'b0;
      ready_data <= '0;
      ready_dc   <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      cs_s       <= {cs_s[0], spi_cs};
      dc_s       <= {dc_s[0], spi_dc};
      mosi_s     <= {mosi_s[0], spi_mosi};
      sclk_s     <= {sclk_s[1:0], spi_sclk};
      byte_ready <= 1'b0;

      // cs high discards any partial byte; a completed byte still goes out
      if (cs_s[1]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_q <= {shift_q[6:0], mosi_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_ready <= 1'b1;
          ready_data <= {shift_q[6:0], mosi_s[1]};
          ready_dc   <= dc_s[1];
        end
      end

      byte_valid <= byte_ready;
      if (byte_ready) begin
        byte_data <= ready_data;
        byte_dc   <= ready_dc;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx_decoder.sv
// LCD SPI loopback monitor: decodes CASET/RASET/RAMWR and emits per-pixel writes with
// screen coordinates, frame-complete pulses and a frame counter.
module lcd_spi_rx_decoder
  import lcd_pkg::*;
#(
  parameter int unsigned H_RES = LCD_H_RES,
  parameter int unsigned V_RES = LCD_V_RES
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        spi_cs,
  input  logic        spi_dc,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pixel_valid,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [7:0]  pixel_data,
  output logic        frame_done,
  output logic        cmd_error,
  output logic [15:0] frame_count
);

  logic       byte_ready;
  logic [7:0] ready_data;
  logic       ready_dc;

  lcd_spi_byte_rx u_byte_rx (
    .clk_25MHz  (clk_25MHz),
    .rst_n      (rst_n),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .byte_ready (byte_ready),
    .ready_data (ready_data),
    .ready_dc   (ready_dc),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  dec_state_e  state_q;
  logic [1:0]  p_q;
  logic [15:0] s_q;
  logic [7:0]  e_hi_q;
  logic [8:0]  xs_q, xe_q, ys_q, ye_q;
  logic [8:0]  x_q, y_q;

  logic [15:0] e_full;
  logic [15:0] limit;
  logic        win_ok;
  logic        x_last, y_last;

  always_comb begin
    e_full = {e_hi_q, ready_data};
    limit  = (state_q == StCaset) ? 16'(H_RES) : 16'(V_RES);
    win_ok = (s_q <= e_full) && (e_full < limit);
    x_last = (x_q == xe_q);
    y_last = (y_q == ye_q);
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      p_q         <= '0;
      s_q         <= '0;
      e_hi_q      <= '0;
      xs_q        <= '0;
      xe_q        <= 9'(H_RES - 1);
      ys_q        <= '0;
      ye_q        <= 9'(V_RES - 1);
      x_q         <= '0;
      y_q         <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_data  <= '0;
      frame_done  <= 1'b0;
      cmd_error   <= 1'b0;
      frame_count <= '0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      cmd_error   <= 1'b0;

      if (byte_ready && !ready_dc) begin
        p_q <= '0;
        case (ready_data)
          CMD_CASET: state_q <= StCaset;
          CMD_RASET: state_q <= StRaset;
          CMD_RAMWR: begin
            state_q <= StRamwr;
            x_q     <= xs_q;
            y_q     <= ys_q;
          end
          default:   state_q <= StIdle;
        endcase
      end else if (byte_ready) begin
        case (state_q)
          StCaset, StRaset: begin
            p_q <= p_q + 2'd1;
            case (p_q)
              2'd0: s_q[15:8] <= ready_data;
              2'd1: s_q[7:0]  <= ready_data;
              2'd2: e_hi_q    <= ready_data;
              default: begin
                if (!win_ok) begin
                  cmd_error <= 1'b1;
                end else if (state_q == StCaset) begin
                  xs_q <= s_q[8:0];
                  xe_q <= e_full[8:0];
                end else begin
                  ys_q <= s_q[8:0];
                  ye_q <= e_full[8:0];
                end
                state_q <= StIdle;
              end
            endcase
          end
          StRamwr: begin
            pixel_valid <= 1'b1;
            pixel_x     <= x_q;
            pixel_y     <= y_q;
            pixel_data  <= ready_data;
            if (x_last && y_last) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              x_q         <= xs_q;
              y_q         <= ys_q;
            end else if (!x_last) begin
              x_q <= x_q + 9'd1;
            end else begin
              x_q <= xs_q;
              y_q <= y_q + 9'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
